seg_display_ctrl: RTL and testbench

Scanned seven-segment display controller between the processor's output-instruction path and the four-digit board display. It captures the 16-bit operand of every committed output instruction (op1 = 2'b11, op3 = 4'b1101) into a display register. A debug requester can take over the display through a req/ack handshake. The block time-multiplexes four hex digits onto one shared segment bus with active-low digit enables.

---
 rtl/seg_display_ctrl.sv | 118 +++++++++++
 tb/tb_seg_display_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Four-digit scanned seven-segment controller with CPU output-instruction capture
// and a req/ack debug takeover of the displayed value.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [1:0]  op1,
  input  logic [3:0]  op3,
  input  logic [15:0] wr_data,
  input  logic        dbg_req,
  input  logic [15:0] dbg_data,
  output logic        dbg_ack,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] shown
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  typedef enum logic {StCpu, StDbg} owner_e;

  owner_e          state_q, state_d;
  logic [15:0]     cpu_val_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      digit_q;
  logic [7:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            wr, tc;
  logic [3:0]      nibble;
  logic            blank;

  assign wr = valid & (op1 == 2'b11) & (op3 == 4'b1101);
  assign tc = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCpu: if (dbg_req)  state_d = StDbg;
      StDbg: if (!dbg_req) state_d = StCpu;
      default: state_d = StCpu;
    endcase
  end

  assign shown   = (state_q == StDbg) ? dbg_data : cpu_val_q;
  assign dbg_ack = (state_q == StDbg);

  // Leading-zero test looks at the digit and everything above it.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    unique case (digit_q)
      2'd0: nibble = shown[3:0];
      2'd1: begin nibble = shown[7:4];   blank = (shown[15:4] == 12'h000); end
      2'd2: begin nibble = shown[11:8];  blank = (shown[15:8] == 8'h00);   end
      2'd3: begin nibble = shown[15:12]; blank = (shown[15:12] == 4'h0);   end
      default: ;
    endcase
  end

  always_comb begin
    seg_d = 8'h00;
    an_d  = 4'b1111;
    if (!tc) begin
      an_d = ~(4'b0001 << digit_q);
      if (!(BLANK_LZ && blank)) begin
        unique case (nibble)
          4'h0: seg_d = 8'hFC;
          4'h1: seg_d = 8'h60;
          4'h2: seg_d = 8'hDA;
          4'h3: seg_d = 8'hF2;
          4'h4: seg_d = 8'h66;
          4'h5: seg_d = 8'hB6;
          4'h6: seg_d = 8'hBE;
          4'h7: seg_d = 8'hE0;
          4'h8: seg_d = 8'hFE;
          4'h9: seg_d = 8'hF6;
          4'hA: seg_d = 8'hEE;
          4'hB: seg_d = 8'h3E;
          4'hC: seg_d = 8'h1A;
          4'hD: seg_d = 8'h7A;
          4'hE: seg_d = 8'h9E;
          4'hF: seg_d = 8'h8E;
          default: seg_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StCpu;
      cpu_val_q <= 16'h0000;
      div_q     <= '0;
      digit_q   <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= 8'hFC;
    end else begin
      state_q <= state_d;
      if (wr) cpu_val_q <= wr_data;
      if (tc) begin
        div_q   <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: cycle-level reference model checked every cycle
// against two instances (no blanking / leading-zero blanking), plus literal spot checks.
module tb_seg_display_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [1:0]  op1;
  logic [3:0]  op3;
  logic [15:0] wr_data;
  logic        dbg_req;
  logic [15:0] dbg_data;
  logic        ack0, ack1;
  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic [15:0] shown0, shown1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(.SCAN_DIV(D), .BLANK_LZ(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .op1(op1), .op3(op3), .wr_data(wr_data),
    .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(ack0), .seg(seg0), .an(an0),
    .shown(shown0)
  );

  seg_display_ctrl #(.SCAN_DIV(D), .BLANK_LZ(1'b1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .valid(valid), .op1(op1), .op3(op3), .wr_data(wr_data),
    .dbg_req(dbg_req), .dbg_data(dbg_data), .dbg_ack(ack1), .seg(seg1), .an(an1),
    .shown(shown1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n counts cycles since the reset edge; outputs in cycle n are a
  // function of the scan position and displayed value of cycle n-1.
  logic [7:0]  enc_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};
  int          n = 0;
  bit          m_live = 1'b0;
  logic        m_dbg = 1'b0;
  logic [15:0] m_cpu = 16'h0;
  logic [15:0] m_prev = 16'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cpu  <= 16'h0;
      m_dbg  <= 1'b0;
      n      <= 0;
      m_live <= 1'b1;
    end else begin
      if (valid && op1 == 2'b11 && op3 == 4'b1101) m_cpu <= wr_data;
      m_dbg  <= dbg_req;
      m_prev <= m_dbg ? dbg_data : m_cpu;
      n      <= n + 1;
    end
  end

  task automatic model_out(input bit blz, output logic [3:0] ea, output logic [7:0] es);
    int          p, pd, pg;
    logic [3:0]  one;
    logic [15:0] upper;
    one = 4'b0001;
    if (n == 0) begin
      ea = 4'b1110;
      es = 8'hFC;
    end else begin
      p  = n - 1;
      pd = p % D;
      pg = (p / D) % 4;
      if (pd == D - 1) begin
        ea = 4'b1111;
        es = 8'h00;
      end else begin
        ea    = ~(one << pg);
        upper = m_prev >> (4 * pg);
        es    = (blz && pg > 0 && upper == 16'h0) ? 8'h00 : enc_tab[upper[3:0]];
      end
    end
  endtask

  always @(negedge clk) begin
    logic [3:0]  ea;
    logic [7:0]  es;
    logic [15:0] eshown;
    if (m_live) begin
      eshown = m_dbg ? dbg_data : m_cpu;
      chk("model shown", {16'h0, shown0}, {16'h0, eshown});
      chk("model shown_lz", {16'h0, shown1}, {16'h0, eshown});
      chk("model ack", {31'h0, ack0}, {31'h0, m_dbg});
      chk("model ack_lz", {31'h0, ack1}, {31'h0, m_dbg});
      model_out(1'b0, ea, es);
      chk("model an", {28'h0, an0}, {28'h0, ea});
      chk("model seg", {24'h0, seg0}, {24'h0, es});
      model_out(1'b1, ea, es);
      chk("model an_lz", {28'h0, an1}, {28'h0, ea});
      chk("model seg_lz", {24'h0, seg1}, {24'h0, es});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_write(input logic [15:0] v);
    valid = 1'b1; op1 = 2'b11; op3 = 4'b1101; wr_data = v;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] v);
    int k = 0;
    while (an0 !== v && k < 64) begin
      step();
      k++;
    end
    if (k >= 64) chk("wait_an timeout", {28'h0, an0}, {28'h0, v});
  endtask

  // Visit each digit (3..0) and compare both instances' segment patterns.
  task automatic digits(input string tag, input logic [31:0] s0, input logic [31:0] s1);
    logic [3:0] one;
    one = 4'b0001;
    for (int d = 3; d >= 0; d--) begin
      wait_an(~(one << d));
      chk({tag, " seg"}, {24'h0, seg0}, {24'h0, s0[8*d +: 8]});
      chk({tag, " seg_lz"}, {24'h0, seg1}, {24'h0, s1[8*d +: 8]});
    end
  endtask

  logic [3:0] seq_an [16] = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
                              4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111,
                              4'b0111, 4'b0111, 4'b1111, 4'b1110};

  initial begin
    rst_n = 1'b0; valid = 1'b0; op1 = 2'b00; op3 = 4'h0; wr_data = 16'h0;
    dbg_req = 1'b0; dbg_data = 16'h0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset an", {28'h0, an0}, 32'hE);
    chk("reset seg", {24'h0, seg0}, 32'hFC);
    chk("reset shown", {16'h0, shown0}, 32'h0);
    chk("reset ack", {31'h0, ack0}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("scan an", {28'h0, an0}, {28'h0, seq_an[i]});
      chk("scan seg", {24'h0, seg0}, (seq_an[i] == 4'b1111) ? 32'h00 : 32'hFC);
    end

    cpu_write(16'h12AF);
    chk("write shown", {16'h0, shown0}, 32'h12AF);
    step();
    digits("12AF", 32'h60DAEE8E, 32'h60DAEE8E);

    valid = 1'b1; op1 = 2'b11; op3 = 4'b1100; wr_data = 16'hFFFF;
    step();
    op3 = 4'b1101; valid = 1'b0;
    step();
    op1 = 2'b10; valid = 1'b1;
    step();
    valid = 1'b0;
    step();
    chk("ignored ops", {16'h0, shown0}, 32'h12AF);

    dbg_req = 1'b1; dbg_data = 16'h00C3;
    step();
    chk("dbg ack", {31'h0, ack0}, 32'h1);
    chk("dbg shown", {16'h0, shown0}, 32'h00C3);
    cpu_write(16'h0005);
    chk("dbg hides write", {16'h0, shown0}, 32'h00C3);
    step();
    dbg_req = 1'b0;
    step();
    chk("release ack", {31'h0, ack0}, 32'h0);
    chk("release shown", {16'h0, shown0}, 32'h0005);

    cpu_write(16'h0040);
    step();
    digits("0040", 32'hFCFC66FC, 32'h000066FC);
    cpu_write(16'h0000);
    step();
    digits("0000", 32'hFCFCFCFC, 32'h000000FC);

    dbg_req = 1'b1; dbg_data = 16'h1111;
    cpu_write(16'hBEEF);
    chk("simul ack", {31'h0, ack0}, 32'h1);
    chk("simul shown", {16'h0, shown0}, 32'h1111);
    dbg_req = 1'b0;
    step();
    chk("simul release", {16'h0, shown0}, 32'hBEEF);

    cpu_write(16'h0001);
    cpu_write(16'h0002);
    cpu_write(16'h0003);
    chk("back-to-back", {16'h0, shown0}, 32'h0003);

    dbg_req = 1'b1; dbg_data = 16'hA5A5;
    step();
    wait_an(4'b1011);
    step();
    rst_n = 1'b0;
    step();
    chk("midrst an", {28'h0, an0}, 32'hE);
    chk("midrst seg", {24'h0, seg0}, 32'hFC);
    chk("midrst ack", {31'h0, ack0}, 32'h0);
    chk("midrst shown", {16'h0, shown0}, 32'h0);
    rst_n = 1'b1;
    step();
    chk("regrant ack", {31'h0, ack0}, 32'h1);
    chk("regrant shown", {16'h0, shown0}, 32'hA5A5);
    dbg_req = 1'b0;
    step();
    chk("cpu_val cleared", {16'h0, shown0}, 32'h0);
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
